// File: rtl/dcm_reset_sequencer_pkg.sv
// DCM reset sequencer shared definitions.
// State codes and elaboration-time sizing helpers.
package dcm_reset_sequencer_pkg;

  localparam logic [1:0] ST_RST_PULSE = 2'd0;
  localparam logic [1:0] ST_WAIT_LOCK = 2'd1;
  localparam logic [1:0] ST_STABLE    = 2'd2;
  localparam logic [1:0] ST_RUN       = 2'd3;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

  function automatic int max3(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/dcm_reset_sequencer_if.sv
// DCM-side control bundle of the reset sequencer.
// master = sequencer, slave = DCM / downstream reset consumers.
interface dcm_reset_sequencer_if #(
  parameter int RETRY_W = 4
);

  logic               locked;
  logic               dcm_rst;
  logic               sys_rst;
  logic               ready;
  logic [RETRY_W-1:0] retry_count;
  logic [1:0]         state;

  modport master (
    input  locked,
    output dcm_rst,
    output sys_rst,
    output ready,
    output retry_count,
    output state
  );

  modport slave (
    output locked,
    input  dcm_rst,
    input  sys_rst,
    input  ready,
    input  retry_count,
    input  state
  );

endinterface

// File: rtl/dcm_reset_sequencer_sync_2ff.sv
// Generic two-flop synchronizer, sync active-low reset.
// Used to bring the asynchronous DCM LOCKED into clk32.
module dcm_reset_sequencer_sync_2ff (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic ff1;
  logic ff2;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ff1 <= 1'b0;
      ff2 <= 1'b0;
    end else begin
      ff1 <= d;
      ff2 <= ff1;
    end
  end

  assign q = ff2;

endmodule

// File: rtl/dcm_reset_sequencer.sv
// Pulses DCM reset, waits for lock with timeout and retry,
// then releases system reset once lock is qualified.
module dcm_reset_sequencer
  import dcm_reset_sequencer_pkg::*;
#(
  parameter int RST_CYCLES    = 8,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int STABLE_CYCLES = 1024,
  parameter int RETRY_W       = 4
) (
  input  logic                  clk32,
  input  logic                  reset_n,
  dcm_reset_sequencer_if.master bus
);

  localparam int CMAX =
    max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam int CW = clog2(CMAX);

  localparam logic [CW-1:0] RST_LAST =
    CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST =
    CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STB_LAST =
    CW'(STABLE_CYCLES - 1);

  logic [1:0]         state;
  logic [1:0]         nxt;
  logic [CW-1:0]      cnt;
  logic [RETRY_W-1:0] retry;
  logic               bump;
  logic               locked_s;

  dcm_reset_sequencer_sync_2ff u_sync (
    .clk     (clk32),
    .reset_n (reset_n),
    .d       (bus.locked),
    .q       (locked_s)
  );

  // Lock wins over a coincident timeout in WAIT_LOCK.
  always_comb begin
    nxt  = state;
    bump = 1'b0;
    unique case (state)
      ST_RST_PULSE: begin
        if (cnt == RST_LAST) nxt = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (locked_s) begin
          nxt = ST_STABLE;
        end else if (cnt == TMO_LAST) begin
          nxt  = ST_RST_PULSE;
          bump = 1'b1;
        end
      end
      ST_STABLE: begin
        if (!locked_s) begin
          nxt  = ST_RST_PULSE;
          bump = 1'b1;
        end else if (cnt == STB_LAST) begin
          nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!locked_s) begin
          nxt  = ST_RST_PULSE;
          bump = 1'b1;
        end
      end
      default: nxt = ST_RST_PULSE;
    endcase
  end

  always_ff @(posedge clk32) begin
    if (!reset_n) begin
      state <= ST_RST_PULSE;
      cnt   <= '0;
      retry <= '0;
    end else begin
      state <= nxt;
      cnt   <= (nxt != state) ? '0 : cnt + CW'(1);
      if (bump && !(&retry)) retry <= retry + 1'b1;
    end
  end

  assign bus.dcm_rst     = (state == ST_RST_PULSE);
  assign bus.sys_rst     = (state != ST_RUN);
  assign bus.ready       = (state == ST_RUN);
  assign bus.retry_count = retry;
  assign bus.state       = state;

endmodule

// File: tb/tb_dcm_reset_sequencer.sv
// Scoreboard bench for dcm_reset_sequencer: directed
// scenarios plus random lock traffic against a timeline model.
module tb_dcm_reset_sequencer;

  localparam int RC = 4;
  localparam int LT = 16;
  localparam int SC = 8;
  localparam int RW = 4;
  localparam int RMAX = (1 << RW) - 1;

  typedef struct packed {
    logic          dcm_rst;
    logic          sys_rst;
    logic          ready;
    logic [RW-1:0] retry;
    logic [1:0]    st;
  } exp_t;

  typedef enum int {
    P_PULSE = 0,
    P_ACQ   = 1,
    P_QUAL  = 2,
    P_LIVE  = 3
  } phase_e;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  dcm_reset_sequencer_if #(.RETRY_W(RW)) bus();

  dcm_reset_sequencer #(
    .RST_CYCLES    (RC),
    .LOCK_TIMEOUT  (LT),
    .STABLE_CYCLES (SC),
    .RETRY_W       (RW)
  ) dut (
    .clk32   (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  exp_t   q[$];
  int     vectors = 0;
  int     miscompares = 0;

  phase_e ph = P_PULSE;
  int     spent = 0;
  int     retries = 0;
  logic   lhist[$];

  // Model of one clock edge: phase timeline with elapsed
  // edge count and a two-sample delay line on locked.
  task automatic model_edge(input logic rn, input logic lk);
    logic   ls;
    int     n;
    phase_e np;
    if (!rn) begin
      ph      = P_PULSE;
      spent   = 0;
      retries = 0;
      lhist   = {1'b0, 1'b0};
      return;
    end
    ls = lhist[0];
    lhist.push_back(lk);
    void'(lhist.pop_front());
    n  = spent + 1;
    np = ph;
    case (ph)
      P_PULSE: if (n == RC) np = P_ACQ;
      P_ACQ: begin
        if (ls) np = P_QUAL;
        else if (n == LT) begin
          np = P_PULSE;
          retries++;
        end
      end
      P_QUAL: begin
        if (!ls) begin
          np = P_PULSE;
          retries++;
        end else if (n == SC) np = P_LIVE;
      end
      default: begin
        if (!ls) begin
          np = P_PULSE;
          retries++;
        end
      end
    endcase
    spent = (np != ph) ? 0 : n;
    ph    = np;
  endtask

  function automatic exp_t expected();
    exp_t e;
    e.dcm_rst = (ph == P_PULSE);
    e.sys_rst = (ph != P_LIVE);
    e.ready   = (ph == P_LIVE);
    e.retry   = RW'((retries > RMAX) ? RMAX : retries);
    e.st      = 2'(int'(ph));
    return e;
  endfunction

  task automatic apply(
    input logic rn,
    input logic lk,
    input int   n
  );
    repeat (n) begin
      @(negedge clk);
      reset_n    = rn;
      bus.locked = lk;
      model_edge(rn, lk);
      q.push_back(expected());
    end
  endtask

  initial begin : monitor
    exp_t e;
    exp_t got;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e   = q.pop_front();
        got = {bus.dcm_rst, bus.sys_rst, bus.ready,
               bus.retry_count, bus.state};
        vectors++;
        if (got !== e) begin
          miscompares++;
          $display({"FAIL vec%0d outputs: got dcm_rst=%b",
                    " sys_rst=%b ready=%b retry=%0d state=%0d;",
                    " want %b %b %b %0d %0d"},
                   vectors, got.dcm_rst, got.sys_rst,
                   got.ready, got.retry, got.st,
                   e.dcm_rst, e.sys_rst, e.ready,
                   e.retry, e.st);
        end
      end
    end
  end

  initial begin : driver
    int   len;
    logic lk;
    logic rn;
    bus.locked = 1'b0;
    // locked tied high from reset release
    apply(1'b0, 1'b1, 3);
    apply(1'b1, 1'b1, 30);
    // never locks: retry saturation
    apply(1'b0, 1'b0, 2);
    apply(1'b1, 1'b0, 20 * 17 + 5);
    // one-cycle lock drop in qualification
    apply(1'b0, 1'b0, 2);
    apply(1'b1, 1'b1, 10);
    apply(1'b1, 1'b0, 1);
    apply(1'b1, 1'b1, 40);
    // lock loss in RUN, then relock
    apply(1'b1, 1'b0, 3);
    apply(1'b1, 1'b1, 40);
    apply(1'b1, 1'b0, 2);
    apply(1'b1, 1'b1, 40);
    // reset pulse mid-RUN with retries pending
    apply(1'b0, 1'b1, 1);
    apply(1'b1, 1'b1, 30);
    // lock seen on the timeout cycle itself
    apply(1'b0, 1'b0, 2);
    apply(1'b1, 1'b0, 17);
    apply(1'b1, 1'b1, 30);
    // neighbour: lock one cycle too late
    apply(1'b0, 1'b0, 2);
    apply(1'b1, 1'b0, 18);
    apply(1'b1, 1'b1, 40);
    // reset mid-pulse
    apply(1'b1, 1'b0, 5);
    apply(1'b0, 1'b0, 1);
    apply(1'b1, 1'b1, 30);
    // random lock traffic with rare resets
    repeat (150) begin
      len = $urandom_range(1, 40);
      lk  = ($urandom_range(0, 3) != 0);
      rn  = ($urandom_range(0, 30) != 0);
      if (!rn) apply(1'b0, lk, 1);
      apply(1'b1, lk, len);
    end
    @(posedge clk);
    #2;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d entries left, want 0",
               q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
